// File: rtl/modsqr_job_sequencer_if.sv
// Job, result and squarer-control signals of the modular-squarer job sequencer.
// The master modport is the sequencer's view; the slave modport is the host/squarer side.
interface modsqr_job_sequencer_if #(
    parameter int MOD_LEN = 1024,
    parameter int T_LEN   = 64
);
    logic               job_valid;
    logic               job_ready;
    logic [MOD_LEN-1:0] job_x;
    logic [T_LEN-1:0]   job_t;
    logic               abort;

    logic               sq_reset;
    logic               sq_start;
    logic [MOD_LEN-1:0] sq_in;
    logic [MOD_LEN-1:0] sq_out;
    logic               sq_valid;

    logic               res_valid;
    logic               res_ready;
    logic [MOD_LEN-1:0] res_y;
    logic [T_LEN-1:0]   res_t;
    logic               res_err;

    logic               busy;
    logic [T_LEN-1:0]   iter_count;

    modport master (
        input  job_valid, job_x, job_t, abort, sq_out, sq_valid, res_ready,
        output job_ready, sq_reset, sq_start, sq_in, res_valid, res_y, res_t, res_err,
               busy, iter_count
    );

    modport slave (
        output job_valid, job_x, job_t, abort, sq_out, sq_valid, res_ready,
        input  job_ready, sq_reset, sq_start, sq_in, res_valid, res_y, res_t, res_err,
               busy, iter_count
    );
endinterface

// File: rtl/modsqr_job_sequencer.sv
// Per-job controller for a free-running modular squarer: reset it, load x once,
// count T valid pulses, return x^(2^T) mod N, with watchdog and abort escape paths.
module modsqr_job_sequencer #(
    parameter int MOD_LEN         = 1024,
    parameter int T_LEN           = 64,
    parameter int SQ_RESET_CYCLES = 8,
    parameter int WDOG_CYCLES     = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    modsqr_job_sequencer_if.master bus
);

    localparam int RC_W = (SQ_RESET_CYCLES > 1) ? $clog2(SQ_RESET_CYCLES) : 1;
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(SQ_RESET_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SQ_RST = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]         state_q,   state_d;
    logic [MOD_LEN-1:0] sq_in_q,   sq_in_d;
    logic [T_LEN-1:0]   t_q,       t_d;
    logic [T_LEN-1:0]   iter_q,    iter_d;
    logic [RC_W-1:0]    rc_q,      rc_d;
    logic [WD_W-1:0]    wd_q,      wd_d;
    logic [MOD_LEN-1:0] res_y_q,   res_y_d;
    logic [T_LEN-1:0]   res_t_q,   res_t_d;
    logic               res_err_q, res_err_d;

    logic               job_ready;
    logic               accept;
    logic               last_pulse;
    logic [T_LEN-1:0]   iter_inc;
    logic               err_exit;
    logic [T_LEN-1:0]   err_cnt;

    assign job_ready  = (state_q == ST_IDLE) && reset;
    assign accept     = bus.job_valid && job_ready;
    assign iter_inc   = iter_q + T_LEN'(1);
    // t_q > 0 whenever RUN is reachable, so t_q-1 cannot underflow and T = all-ones is safe
    assign last_pulse = bus.sq_valid && (iter_q == (t_q - T_LEN'(1)));

    always_comb begin
        state_d   = state_q;
        sq_in_d   = sq_in_q;
        t_d       = t_q;
        iter_d    = iter_q;
        rc_d      = rc_q;
        wd_d      = wd_q;
        res_y_d   = res_y_q;
        res_t_d   = res_t_q;
        res_err_d = res_err_q;
        err_exit  = 1'b0;
        err_cnt   = iter_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sq_in_d   = bus.job_x;
                    t_d       = bus.job_t;
                    iter_d    = '0;
                    wd_d      = '0;
                    res_err_d = 1'b0;
                    if (bus.job_t == '0) begin
                        res_y_d = bus.job_x;
                        res_t_d = '0;
                        state_d = ST_DONE;
                    end else begin
                        rc_d    = RC_LOAD;
                        state_d = ST_SQ_RST;
                    end
                end
            end
            ST_SQ_RST: begin
                if (bus.abort) begin
                    err_exit = 1'b1;
                end else if (rc_q == '0) begin
                    state_d = ST_LOAD;
                end else begin
                    rc_d = rc_q - RC_W'(1);
                end
            end
            ST_LOAD: begin
                wd_d = '0;
                if (bus.abort) begin
                    err_exit = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // The final pulse outranks abort and watchdog in the same cycle
                if (bus.sq_valid) begin
                    iter_d = iter_inc;
                    wd_d   = '0;
                    if (last_pulse) begin
                        res_y_d   = bus.sq_out;
                        res_t_d   = t_q;
                        res_err_d = 1'b0;
                        state_d   = ST_DONE;
                    end else if (bus.abort) begin
                        err_exit = 1'b1;
                        err_cnt  = iter_inc;
                    end
                end else if (bus.abort || (wd_q == WD_LAST)) begin
                    err_exit = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (err_exit) begin
            state_d   = ST_DONE;
            res_err_d = 1'b1;
            res_y_d   = '0;
            res_t_d   = err_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            sq_in_q   <= '0;
            t_q       <= '0;
            iter_q    <= '0;
            rc_q      <= '0;
            wd_q      <= '0;
            res_y_q   <= '0;
            res_t_q   <= '0;
            res_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sq_in_q   <= sq_in_d;
            t_q       <= t_d;
            iter_q    <= iter_d;
            rc_q      <= rc_d;
            wd_q      <= wd_d;
            res_y_q   <= res_y_d;
            res_t_q   <= res_t_d;
            res_err_q <= res_err_d;
        end
    end

    assign bus.job_ready  = job_ready;
    assign bus.sq_reset   = (state_q != ST_LOAD) && (state_q != ST_RUN);
    assign bus.sq_start   = (state_q == ST_LOAD);
    assign bus.sq_in      = sq_in_q;
    assign bus.res_valid  = (state_q == ST_DONE);
    assign bus.res_y      = res_y_q;
    assign bus.res_t      = res_t_q;
    assign bus.res_err    = res_err_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.iter_count = iter_q;

endmodule

// File: tb/tb_modsqr_job_sequencer.sv
// Bench for modsqr_job_sequencer: behavioural squarer (mod 1019) plus a table of
// known jobs, hand-written corner sequences and random jobs checked against x^(2^T) mod N.
module tb_modsqr_job_sequencer;

    localparam int     ML  = 16;
    localparam int     TL  = 8;
    localparam int     SRC = 8;
    localparam int     WDC = 16;
    localparam longint N   = 1019;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    modsqr_job_sequencer_if #(.MOD_LEN(ML), .T_LEN(TL)) bus ();

    modsqr_job_sequencer #(
        .MOD_LEN(ML), .T_LEN(TL), .SQ_RESET_CYCLES(SRC), .WDOG_CYCLES(WDC)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // squarer model controls / observations
    int     period         = 1;
    bit     sq_en          = 1'b1;
    int     abort_cyc      = -1;
    int     abort_pulse    = 0;
    int     pulses         = 0;
    int     starts         = 0;
    int     start_cyc      = -1;
    int     last_pulse_cyc = -1;
    int     max_iter       = 0;

    function automatic longint ref_pow(input longint x, input int t);
        longint y;
        y = x % N;
        for (int i = 0; i < t; i++) y = (y * y) % N;
        return y;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Free-running squarer: loads on sq_start, squares mod N every 'period' cycles.
    initial begin : squarer_model
        bit     active;
        bit     fired;
        int     phase;
        longint mval;
        active = 1'b0; phase = 0; mval = 0;
        bus.sq_valid = 1'b0;
        bus.sq_out   = '0;
        bus.abort    = 1'b0;
        forever begin
            @(negedge clk);
            fired = 1'b0;
            if (bus.sq_reset === 1'b1) begin
                active = 1'b0;
            end else if (bus.sq_start === 1'b1) begin
                starts++;
                start_cyc = cyc;
                active    = 1'b1;
                phase     = 0;
                pulses    = 0;
                mval      = longint'(bus.sq_in);
            end else if (active && sq_en) begin
                phase++;
                if (phase >= period) begin
                    phase = 0;
                    mval  = (mval * mval) % N;
                    pulses++;
                    fired = 1'b1;
                    last_pulse_cyc = cyc;
                end
            end
            bus.sq_valid = fired;
            bus.sq_out   = ML'(mval);
            bus.abort    = (cyc == abort_cyc) || (fired && (pulses == abort_pulse));
            if (int'(bus.iter_count) > max_iter) max_iter = int'(bus.iter_count);
        end
    end

    task automatic offer(input logic [ML-1:0] x, input logic [TL-1:0] t, output int acc);
        bit ok;
        ok  = 1'b0;
        acc = -1;
        @(negedge clk);
        bus.job_x     = x;
        bus.job_t     = t;
        bus.job_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus.job_ready === 1'b1) begin
                ok  = 1'b1;
                acc = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        else check("accept_timeout", 64'd0, 64'd1);
        bus.job_valid = 1'b0;
    endtask

    task automatic wait_res(input int budget, output int rcyc);
        rcyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (bus.res_valid === 1'b1) begin
                rcyc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (rcyc < 0) check("res_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_iter(input int n, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (int'(bus.iter_count) == n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("iter_timeout", 64'd0, 64'd1);
    endtask

    task automatic take_result(input string tag);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(bus.res_valid), 64'd0);
        check({tag, "_idle_ready"}, 64'(bus.job_ready), 64'd1);
    endtask

    task automatic check_result(input string tag, input longint y, input int t, input bit err);
        check({tag, "_y"},   64'(bus.res_y),   64'(y));
        check({tag, "_t"},   64'(bus.res_t),   64'(t));
        check({tag, "_err"}, 64'(bus.res_err), 64'(err));
    endtask

    typedef struct {
        logic [ML-1:0] x;
        logic [TL-1:0] t;
        int            period;
        logic [ML-1:0] exp_y;
    } vec_t;

    vec_t vecs[7];

    initial begin : main
        int acc;
        int rcyc;
        int bad;
        int c;
        logic [ML-1:0] sy;
        logic [TL-1:0] st;
        logic          se;
        logic [ML-1:0] rx;
        int            rt;

        vecs[0] = '{16'd5,    8'd0, 1,  16'd5};
        vecs[1] = '{16'd3,    8'd4, 10, 16'd85};
        vecs[2] = '{16'd2,    8'd1, 1,  16'd4};
        vecs[3] = '{16'd2,    8'd3, 3,  16'd256};
        vecs[4] = '{16'd10,   8'd2, 5,  16'd829};
        vecs[5] = '{16'd1018, 8'd1, 2,  16'd1};
        vecs[6] = '{16'd0,    8'd5, 1,  16'd0};

        reset         = 1'b0;
        bus.job_valid = 1'b0;
        bus.job_x     = '0;
        bus.job_t     = '0;
        bus.res_ready = 1'b0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_job_ready", 64'(bus.job_ready),  64'd0);
        check("rst_busy",      64'(bus.busy),       64'd0);
        check("rst_sq_reset",  64'(bus.sq_reset),   64'd1);
        check("rst_sq_start",  64'(bus.sq_start),   64'd0);
        check("rst_sq_in",     64'(bus.sq_in),      64'd0);
        check("rst_res_valid", 64'(bus.res_valid),  64'd0);
        check("rst_res_y",     64'(bus.res_y),      64'd0);
        check("rst_res_t",     64'(bus.res_t),      64'd0);
        check("rst_res_err",   64'(bus.res_err),    64'd0);
        check("rst_iter",      64'(bus.iter_count), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(bus.job_ready), 64'd1);

        // table of known jobs
        for (int i = 0; i < 7; i++) begin
            period = vecs[i].period;
            starts = 0;
            offer(vecs[i].x, vecs[i].t, acc);
            wait_res(400, rcyc);
            check_result($sformatf("vec%0d", i), longint'(vecs[i].exp_y), int'(vecs[i].t), 1'b0);
            if (vecs[i].t == '0) begin
                check($sformatf("vec%0d_starts", i), 64'(starts), 64'd0);
                check($sformatf("vec%0d_lat", i),    64'(rcyc),   64'(acc));
            end else begin
                check($sformatf("vec%0d_starts", i),    64'(starts),              64'd1);
                check($sformatf("vec%0d_start_lat", i), 64'(start_cyc - acc),     64'(SRC));
                check($sformatf("vec%0d_res_lat", i),   64'(rcyc - last_pulse_cyc), 64'd1);
            end
            take_result($sformatf("vec%0d", i));
        end

        // result held under back-pressure; a new job is not taken meanwhile
        period = 2;
        offer(16'd7, 8'd2, acc);
        wait_res(200, rcyc);
        check_result("hold", ref_pow(7, 2), 2, 1'b0);
        sy = bus.res_y; st = bus.res_t; se = bus.res_err;
        bus.job_x = 16'd11; bus.job_t = 8'd1; bus.job_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.res_y !== sy || bus.res_t !== st || bus.res_err !== se ||
                bus.res_valid !== 1'b1 || bus.job_ready !== 1'b0) bad++;
        end
        check("hold_stable", 64'(bad), 64'd0);
        bus.job_valid = 1'b0;
        take_result("hold");
        check("hold_idle_busy", 64'(bus.busy), 64'd0);

        // watchdog: squarer never pulses
        sq_en = 1'b0;
        offer(16'd9, 8'd3, acc);
        wait_res(200, rcyc);
        check_result("wdog", 0, 0, 1'b1);
        check("wdog_lat", 64'(rcyc - (start_cyc + 1)), 64'(WDC));
        take_result("wdog");
        sq_en = 1'b1;

        // abort coincident with the final pulse: completion wins
        period = 3; abort_pulse = 4;
        offer(16'd3, 8'd4, acc);
        wait_res(200, rcyc);
        check_result("abort_final", ref_pow(3, 4), 4, 1'b0);
        take_result("abort_final");
        abort_pulse = 0;

        // abort during SQ_RST
        starts = 0;
        offer(16'd6, 8'd5, acc);
        abort_cyc = acc + 2;
        wait_res(100, rcyc);
        check_result("abort_rst", 0, 0, 1'b1);
        check("abort_rst_lat",    64'(rcyc),   64'(acc + 3));
        check("abort_rst_starts", 64'(starts), 64'd0);
        take_result("abort_rst");
        abort_cyc = -1;

        // abort in RUN between pulses
        period = 4;
        offer(16'd5, 8'd6, acc);
        wait_iter(2, 200);
        c = cyc;
        abort_cyc = c + 1;
        wait_res(50, rcyc);
        check_result("abort_run", 0, 2, 1'b1);
        take_result("abort_run");

        // abort ignored while idle
        abort_cyc = cyc + 1;
        repeat (3) @(negedge clk);
        check("abort_idle_busy",  64'(bus.busy),      64'd0);
        check("abort_idle_valid", 64'(bus.res_valid), 64'd0);
        abort_cyc = -1;

        // reset during RUN discards the job
        period = 3;
        offer(16'd4, 8'd5, acc);
        wait_iter(1, 200);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy",   64'(bus.busy),       64'd0);
        check("midrst_sqrst",  64'(bus.sq_reset),   64'd1);
        check("midrst_iter",   64'(bus.iter_count), 64'd0);
        check("midrst_ready",  64'(bus.job_ready),  64'd0);
        check("midrst_res_y",  64'(bus.res_y),      64'd0);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b0) bad++;
        end
        check("midrst_no_result", 64'(bad), 64'd0);

        // maximum T: iter_count reaches T without overflow
        period = 1; max_iter = 0;
        offer(16'd2, 8'd255, acc);
        wait_res(400, rcyc);
        check_result("tmax", ref_pow(2, 255), 255, 1'b0);
        check("tmax_iter_peak", 64'(max_iter), 64'd255);
        take_result("tmax");

        // random jobs against the arithmetic reference
        for (int k = 0; k < 10; k++) begin
            rx     = ML'($urandom_range(0, 1018));
            rt     = int'($urandom_range(0, 7));
            period = int'($urandom_range(1, 5));
            offer(rx, TL'(rt), acc);
            wait_res(200, rcyc);
            check_result($sformatf("rnd%0d", k), ref_pow(longint'(rx), rt), rt, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check($sformatf("rnd%0d_held", k), 64'(bus.res_y), 64'(ref_pow(longint'(rx), rt)));
            take_result($sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : global_guard
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
